// File: rtl/srl_fifo_ctrl_pkg.sv
// rtl/srl_fifo_ctrl_pkg.sv - shared constants, count-update opcodes and clog2 helper
package srl_fifo_ctrl_pkg;

    localparam int DEF_DEPTH    = 16;
    localparam int DEF_WIDTH    = 16;
    localparam int DEF_AF_LEVEL = 12;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_INC   = 2'd1,
        OP_DEC   = 2'd2,
        OP_FLUSH = 2'd3
    } cnt_op_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/srl_fifo_ctrl_if.sv
// rtl/srl_fifo_ctrl_if.sv - FIFO control/data bundle with producer (master) and FIFO (slave) views
interface srl_fifo_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 5
);
    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic             afull;
    logic [AW-1:0]    count;
    logic             ovfl;
    logic             unfl;

    modport master (
        output flush, wr_en, din, rd_en, clr_err,
        input  dout, empty, full, afull, count, ovfl, unfl
    );

    modport slave (
        input  flush, wr_en, din, rd_en, clr_err,
        output dout, empty, full, afull, count, ovfl, unfl
    );
endinterface

// File: rtl/srl_nxm_addr.sv
// rtl/srl_nxm_addr.sv - WIDTH x DEPTH addressable shift-register bank, no reset
module srl_nxm_addr #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int ABITS = 4
) (
    input  logic             i_clk,
    input  logic             i_ce,
    input  logic [ABITS-1:0] i_a,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_d
);

    // Left unreset so the bank maps onto SRL primitives.
    (* srl_style = "srl" *) logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_ce) begin
            r_sr[0] <= i_d;
            for (int k = 1; k < DEPTH; k++) begin
                r_sr[k] <= r_sr[k-1];
            end
        end
    end

    generate
        if (DEPTH == (1 << ABITS)) begin : g_pow2
            assign o_d = r_sr[i_a];
        end else begin : g_npow2
            assign o_d = (i_a < ABITS'(DEPTH)) ? r_sr[i_a] : '0;
        end
    endgenerate

endmodule

// File: rtl/srl_fifo_ctrl.sv
// rtl/srl_fifo_ctrl.sv - first-word-fall-through FIFO: count/flag registers and tap/CE sequencing
module srl_fifo_ctrl
    import srl_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int AF_LEVEL = DEF_AF_LEVEL
) (
    input  logic           i_clk,
    input  logic           i_rst,
    srl_fifo_ctrl_if.slave bus
);

    localparam int AW    = clog2(DEPTH + 1);
    localparam int ABITS = clog2(DEPTH);

    logic [AW-1:0]    r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_afull;
    logic             r_ovfl;
    logic             r_unfl;

    logic [AW-1:0]    w_count_nxt;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_shift;
    logic             w_ovfl_set;
    logic             w_unfl_set;
    cnt_op_e          w_op;
    logic [ABITS-1:0] w_tap;
    logic [WIDTH-1:0] w_bank_q;

    always_comb begin
        w_wr_ok    = bus.wr_en & (~r_full | bus.rd_en);
        w_rd_ok    = bus.rd_en & ~r_empty;
        w_shift    = w_wr_ok & ~bus.flush;
        w_ovfl_set = bus.wr_en & ~w_wr_ok & ~bus.flush;
        w_unfl_set = bus.rd_en & r_empty & ~bus.flush;

        w_op = OP_HOLD;
        if (bus.flush) begin
            w_op = OP_FLUSH;
        end else if (w_wr_ok & ~w_rd_ok) begin
            w_op = OP_INC;
        end else if (w_rd_ok & ~w_wr_ok) begin
            w_op = OP_DEC;
        end

        w_count_nxt = r_count;
        unique case (w_op)
            OP_INC:   w_count_nxt = r_count + AW'(1);
            OP_DEC:   w_count_nxt = r_count - AW'(1);
            OP_FLUSH: w_count_nxt = '0;
            OP_HOLD:  w_count_nxt = r_count;
        endcase
    end

    // Oldest word lives at tap COUNT-1; the wrap at COUNT==0 is hidden by the DOUT mask.
    assign w_tap = ABITS'(r_count) - ABITS'(1);

    srl_nxm_addr #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ABITS (ABITS)
    ) u_bank (
        .i_clk (i_clk),
        .i_ce  (w_shift),
        .i_a   (w_tap),
        .i_d   (bus.din),
        .o_d   (w_bank_q)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_ovfl  <= 1'b0;
            r_unfl  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == AW'(DEPTH));
            r_afull <= (w_count_nxt >= AW'(AF_LEVEL));
            // A fresh error outranks a same-cycle clear.
            r_ovfl  <= w_ovfl_set | (r_ovfl & ~bus.clr_err);
            r_unfl  <= w_unfl_set | (r_unfl & ~bus.clr_err);
        end
    end

    assign bus.dout  = r_empty ? '0 : w_bank_q;
    assign bus.empty = r_empty;
    assign bus.full  = r_full;
    assign bus.afull = r_afull;
    assign bus.count = r_count;
    assign bus.ovfl  = r_ovfl;
    assign bus.unfl  = r_unfl;

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// tb/tb_srl_fifo_ctrl.sv - table-driven checks of srl_fifo_ctrl plus hand-written reset sequence
module tb_srl_fifo_ctrl;

    logic clk;
    logic rst;

    srl_fifo_ctrl_if #(.WIDTH(16), .AW(5)) bus ();

    srl_fifo_ctrl #(
        .DEPTH    (16),
        .WIDTH    (16),
        .AF_LEVEL (12)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        wr;
        logic        rd;
        logic        clr;
        logic [15:0] din;
        logic [15:0] dout;
        logic [4:0]  count;
        logic        empty;
        logic        full;
        logic        afull;
        logic        ovfl;
        logic        unfl;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    function automatic vec_t mk(input logic flush, input logic wr, input logic rd, input logic clr,
                                input logic [15:0] din, input logic [15:0] dout, input int count,
                                input logic ovfl, input logic unfl);
        vec_t v;
        v.flush = flush;
        v.wr    = wr;
        v.rd    = rd;
        v.clr   = clr;
        v.din   = din;
        v.dout  = dout;
        v.count = 5'(count);
        v.empty = (count == 0);
        v.full  = (count == 16);
        v.afull = (count >= 12);
        v.ovfl  = ovfl;
        v.unfl  = unfl;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] dout, input logic [4:0] count,
                         input logic empty, input logic full, input logic afull,
                         input logic ovfl, input logic unfl);
        n_total = n_total + 1;
        if ({bus.dout, bus.count, bus.empty, bus.full, bus.afull, bus.ovfl, bus.unfl} ===
            {dout, count, empty, full, afull, ovfl, unfl}) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got dout=%h cnt=%0d e=%b f=%b af=%b ov=%b un=%b, want dout=%h cnt=%0d e=%b f=%b af=%b ov=%b un=%b",
                     name, bus.dout, bus.count, bus.empty, bus.full, bus.afull, bus.ovfl, bus.unfl,
                     dout, count, empty, full, afull, ovfl, unfl);
        end
    endtask

    task automatic drive(input logic flush, input logic wr, input logic rd, input logic clr,
                         input logic [15:0] din);
        bus.flush   = flush;
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.clr_err = clr;
        bus.din     = din;
    endtask

    task automatic apply(input vec_t v, input string name);
        drive(v.flush, v.wr, v.rd, v.clr, v.din);
        @(posedge clk);
        #1;
        check(name, v.dout, v.count, v.empty, v.full, v.afull, v.ovfl, v.unfl);
    endtask

    initial begin
        logic [15:0] drain [16];

        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        drive(0, 0, 0, 0, 16'h0000);

        for (int i = 0; i < 12; i++) drain[i] = 16'(4 + i);
        for (int k = 0; k < 4; k++)  drain[12 + k] = 16'(16'h0100 + k);

        // Three writes then three reads
        vecs.push_back(mk(0, 1, 0, 0, 16'h0001, 16'h0001, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0002, 16'h0001, 2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0003, 16'h0001, 3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0002, 2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0003, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0));
        // Fill to full, then one dropped write
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 1, 0, 0, 16'(i), 16'h0000, i + 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h00FF, 16'h0000, 16, 1, 0));
        // Simultaneous write+read while full
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 1, 1, 0, 16'(16'h0100 + k), 16'(k + 1), 16, 1, 0));
        // Drain: current head is 0x0004
        for (int j = 1; j <= 16; j++)
            vecs.push_back(mk(0, 0, 1, 0, 16'h0000, (j < 16) ? drain[j] : 16'h0000, 16 - j, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0));
        // Empty with write+read together
        vecs.push_back(mk(0, 1, 1, 0, 16'hABCD, 16'hABCD, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'hABCD, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0));
        // New error beats same-cycle clear
        vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 1));
        // Fill to 5 then flush with a write
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 0, 0, 16'(16'h0010 + i), 16'h0010, i + 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 16'h0077, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0042, 16'h0042, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0));

        #12;
        check("reset", 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset mid-burst at COUNT=7
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, 0, 0, 16'(16'h0020 + i));
            @(posedge clk);
            #1;
        end
        check("pre_rst", 16'h0020, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(0, 1, 0, 0, 16'h0099);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 16'h0000);
        @(posedge clk);
        #1;
        check("rst_hold", 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(0, 1, 0, 0, 16'h5A5A);
        @(posedge clk);
        #1;
        check("post_rst_wr", 16'h5A5A, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
